dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-ported 4096 x 64-bit data memory array.
- Shares the array between the CPU memory stage (port C) and the debug/program-loader port (port D).
- Issues one access per grant, range-checks every address, and returns registered read data with a completion pulse.
- Feeds the ADR status path through the per-port error flag.

Parameters:
- DATA_W, 64, data word width.
- ADDR_W, 64, requester address width (word index).
- MEM_DEPTH, 4096, number of valid words; legal addresses are 0..MEM_DEPTH-1.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- c_req  in  1  CPU request; held until c_gnt is seen.
- c_we  in  1  CPU 1 = write, 0 = read.
- c_addr  in  ADDR_W  CPU word address.
- c_wdata  in  DATA_W  CPU write data.
- c_gnt  out  1  CPU access being performed this cycle.
- c_done  out  1  CPU completion pulse, 1 cycle.
- c_rdata  out  DATA_W  CPU read data, valid with c_done.
- c_err  out  1  CPU address error, valid with c_done.
- d_req, d_we, d_addr, d_wdata  in  same widths and meanings as the CPU inputs, for the debug port.
- d_gnt, d_done, d_rdata, d_err  out  same widths and meanings as the CPU outputs, for the debug port.
- mem_addr  out  12  array word index (low bits of latched address).
- mem_wdata  out  DATA_W  array write data.
- mem_we  out  1  array write enable; array writes on clk rising edge.
- mem_re  out  1  array read enable.
- mem_rdata  in  DATA_W  combinational array read data for mem_addr.
- busy  out  1  state != IDLE.
- err_count  out  ERR_CNT_W  saturating count of out-of-range accesses.

Behaviour:
- Reset (async, immediate) drives the FSM to IDLE and every output to 0: gnt, done, rdata, err, mem_*, busy, err_count.
- Reset sets last_owner = D, so the CPU wins the first tie.
- Reset mid-access drops the transaction. No array write occurs, because mem_we is decoded from state = ACC and falls with reset.
- FSM states:
  - IDLE: on an edge with any request sampled, select a winner; latch owner, we, addr, wdata; go to ACC.
  - ACC, one cycle: owner's gnt = 1. Drive mem_addr = addr[11:0] and mem_wdata.
    - In range: mem_we = we, mem_re = ~we.
    - Out of range (addr >= MEM_DEPTH): mem_we = mem_re = 0.
    - At the closing edge: rdata_reg <= in-range read ? mem_rdata : 0; err_reg <= out-of-range; increment err_count if out of range (saturates at all-ones); last_owner <= owner; go to RESP.
  - RESP, one cycle: owner's done = 1 and owner's rdata/err = registers. Non-owner done/err = 0.
    - rdata holds its value until the next RESP for that port.
    - At the closing edge: if any request, arbitrate and go to ACC directly; else go to IDLE.
- Arbitration:
  - Single requester: it wins.
  - Both requesting: the port != last_owner wins (round-robin). Neither port can be starved beyond one access.
- Handshake:
  - A requester keeps req, we, addr, wdata stable until the edge ending its gnt cycle. It may drop or change them from the next cycle.
  - Requests are sampled only in IDLE and at the RESP closing edge. A request present during ACC that is still asserted at RESP is considered then.
- Latency: request sampled at edge N → gnt during cycle N..N+1 → done/rdata during N+1..N+2. Peak throughput is one access per 2 cycles.
- Write data is written to the array at the edge closing ACC.
- Read-after-write to the same address by the other port sees the new data.
- Address comparison uses the full ADDR_W bits, so very large addresses with low bits in range still error.

Test Plan:
- CPU write addr 5 data 0xDEAD_BEEF, then CPU read addr 5 → c_gnt 1 cycle each; second c_done with c_rdata = 0xDEADBEEF, c_err = 0; d_* outputs stay 0.
- c_req and d_req asserted the same cycle after reset, both reading addr 0 → CPU granted first, D second; each done pulse on its own port; sustained dual requests alternate C, D, C, D.
- D read addr 4096 and addr 0x1_0000_0005 → d_err = 1, d_rdata = 0, mem_we/mem_re never high, err_count = 2; 300 bad accesses leave err_count = 255.
- D writes addr 7 = 0x11, then CPU reads addr 7 back-to-back → c_rdata = 0x11; busy stays high with no IDLE cycle between the accesses.
- Assert rst during an ACC write to addr 9 (old value 0x22) → outputs 0 immediately, then read addr 9 = 0x22 and err_count = 0.
- Single-cycle idle gaps: c_req pulses whose gnt cycle ends the request → exactly one access per request, no duplicate done pulses.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter and sequencer for the 4096 x 64 data memory
module dmem_arbiter #(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 64,
    parameter int MEM_DEPTH = 4096,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 c_req,
    input  logic                 c_we,
    input  logic [ADDR_W-1:0]    c_addr,
    input  logic [DATA_W-1:0]    c_wdata,
    output logic                 c_gnt,
    output logic                 c_done,
    output logic [DATA_W-1:0]    c_rdata,
    output logic                 c_err,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [ADDR_W-1:0]    d_addr,
    input  logic [DATA_W-1:0]    d_wdata,
    output logic                 d_gnt,
    output logic                 d_done,
    output logic [DATA_W-1:0]    d_rdata,
    output logic                 d_err,
    output logic [11:0]          mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    output logic                 mem_we,
    output logic                 mem_re,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RESP = 2'd2
    } state_t;

    // owner / last_owner encoding: 0 = CPU port, 1 = debug port
    state_t                 state;
    logic                   owner;
    logic                   last_owner;
    logic                   we_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [DATA_W-1:0]      wdata_q;
    logic                   err_q;
    logic [DATA_W-1:0]      c_rdata_q;
    logic [DATA_W-1:0]      d_rdata_q;
    logic [ERR_CNT_W-1:0]   err_count_q;

    logic any_req;
    logic win_d;
    logic in_range;
    logic in_acc;
    logic in_resp;
    logic [DATA_W-1:0] acc_rdata;

    // Round-robin pick: the debug port wins alone, or on a tie when the CPU owned the last access
    always_comb begin
        any_req   = c_req | d_req;
        win_d     = d_req & (~c_req | ~last_owner);
        in_range  = (addr_q < ADDR_W'(MEM_DEPTH));
        in_acc    = (state == ACC);
        in_resp   = (state == RESP);
        acc_rdata = (in_range && !we_q) ? mem_rdata : '0;
    end

    // Sequencer: IDLE -> ACC (one array access) -> RESP (completion), with direct RESP -> ACC chaining
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last_owner  <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            c_rdata_q   <= '0;
            d_rdata_q   <= '0;
            err_count_q <= '0;
        end else begin
            case (state)
                IDLE, RESP: begin
                    if (any_req) begin
                        owner   <= win_d;
                        we_q    <= win_d ? d_we    : c_we;
                        addr_q  <= win_d ? d_addr  : c_addr;
                        wdata_q <= win_d ? d_wdata : c_wdata;
                        state   <= ACC;
                    end else begin
                        state   <= IDLE;
                    end
                end
                ACC: begin
                    if (owner) begin
                        d_rdata_q <= acc_rdata;
                    end else begin
                        c_rdata_q <= acc_rdata;
                    end
                    err_q <= ~in_range;
                    if (!in_range && (err_count_q != {ERR_CNT_W{1'b1}})) begin
                        err_count_q <= err_count_q + ERR_CNT_W'(1);
                    end
                    last_owner <= owner;
                    state      <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decoded from registered state only, so reset clears them immediately
    always_comb begin
        c_gnt     = in_acc & ~owner;
        d_gnt     = in_acc & owner;
        c_done    = in_resp & ~owner;
        d_done    = in_resp & owner;
        c_err     = c_done & err_q;
        d_err     = d_done & err_q;
        c_rdata   = c_rdata_q;
        d_rdata   = d_rdata_q;
        mem_addr  = in_acc ? addr_q[11:0] : 12'd0;
        mem_wdata = in_acc ? wdata_q : '0;
        mem_we    = in_acc & in_range & we_q;
        mem_re    = in_acc & in_range & ~we_q;
        busy      = (state != IDLE);
        err_count = err_count_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with array model and reference scoreboard
module tb_dmem_arbiter;

    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_req, c_we, d_req, d_we;
    logic [63:0] c_addr, c_wdata, d_addr, d_wdata;
    logic        c_gnt, c_done, c_err, d_gnt, d_done, d_err;
    logic [63:0] c_rdata, d_rdata;
    logic [11:0] mem_addr;
    logic [63:0] mem_wdata, mem_rdata;
    logic        mem_we, mem_re, busy;
    logic [7:0]  err_count;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_done(c_done), .c_rdata(c_rdata), .c_err(c_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .busy(busy), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Single-ported array: combinational read, write on rising edge
    logic [63:0] tmem [DEPTH];
    assign mem_rdata = tmem[mem_addr];
    always @(posedge clk) if (mem_we) tmem[mem_addr] <= mem_wdata;

    wire [1:0] gnt_w  = {d_gnt, c_gnt};
    wire [1:0] done_w = {d_done, c_done};
    wire [1:0] err_w  = {d_err, c_err};
    logic [63:0] rd_w [2];
    assign rd_w[0] = c_rdata;
    assign rd_w[1] = d_rdata;

    int n_run = 0;
    int n_fail = 0;

    // Reference model state
    logic [63:0] ref_mem [DEPTH];
    int          ref_errs;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int p, input logic req, input logic we,
                         input logic [63:0] addr, input logic [63:0] wdata);
        if (p == 0) begin
            c_req = req; c_we = we; c_addr = addr; c_wdata = wdata;
        end else begin
            d_req = req; d_we = we; d_addr = addr; d_wdata = wdata;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        rst = 1'b1;
        cyc();
        chk("rst_ctl", {busy, mem_we, mem_re, gnt_w, done_w, err_w}, 0);
        chk("rst_rdata", c_rdata | d_rdata, 0);
        chk("rst_mem", {mem_addr, mem_wdata}, 0);
        chk("rst_errcnt", err_count, 0);
        rst = 1'b0;
        cyc();
    endtask

    // One isolated access: request, check grant cycle, release after it, check completion
    task automatic access(input int p, input logic we, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [63:0] exp_rd,
                          input logic exp_err, input string tag);
        logic inr;
        inr = (addr < 64'd4096);
        drive(p, 1, we, addr, wdata);
        cyc();
        chk({tag, ".gnt"}, gnt_w, (p == 0) ? 2'b01 : 2'b10);
        chk({tag, ".memen"}, {mem_we, mem_re}, {inr && we, inr && !we});
        if (inr) chk({tag, ".maddr"}, mem_addr, addr[11:0]);
        cyc();
        drive(p, 0, we, addr, wdata);
        chk({tag, ".done"}, done_w, (p == 0) ? 2'b01 : 2'b10);
        chk({tag, ".rdata"}, rd_w[p], exp_rd);
        chk({tag, ".err"}, err_w, exp_err ? ((p == 0) ? 2'b01 : 2'b10) : 2'b00);
    endtask

    function automatic logic [63:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7)      return 64'($urandom_range(0, 15));
        else if (r < 9) return 64'($urandom_range(4090, 4101));
        else            return {32'($urandom_range(1, 255)), 20'h0, 12'($urandom_range(0, 15))};
    endfunction

    // Random-phase agent and scoreboard state, index 0 = CPU, 1 = debug
    logic        a_req  [2];
    logic        a_pend [2];
    logic        a_rel  [2];
    logic        a_we   [2];
    logic [63:0] a_addr [2];
    logic [63:0] a_wdata[2];
    int          a_wait [2];
    logic        x_done [2];
    logic        x_err  [2];
    logic [63:0] x_rd   [2];
    logic [63:0] hold_rd[2];

    initial begin
        int n, bad, dn, gn;
        rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            tmem[i]    = '0;
            ref_mem[i] = '0;
        end

        // CPU write then read-back, debug side untouched
        do_reset();
        access(0, 1, 64'd5, 64'hDEAD_BEEF, 64'h0, 0, "c_wr5");
        access(0, 0, 64'd5, 64'h0, 64'hDEAD_BEEF, 0, "c_rd5");
        chk("c_rd5.dside", {d_gnt, d_done, d_err, d_rdata}, 0);
        cyc();
        chk("c_rd5.idle", {gnt_w, done_w, busy}, 0);
        ref_mem[5] = 64'hDEAD_BEEF;

        // Simultaneous first requests: CPU wins, then debug, then strict alternation
        do_reset();
        drive(0, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        cyc();
        chk("tie.first", gnt_w, 2'b01);
        cyc();
        drive(0, 0, 0, 0, 0);
        chk("tie.cdone", {gnt_w, done_w}, 4'b0001);
        cyc();
        chk("tie.second", gnt_w, 2'b10);
        cyc();
        chk("tie.ddone", {gnt_w, done_w}, 4'b0010);
        drive(0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("alt.gnt", gnt_w, (i % 2 == 1) ? 2'b00 : (((i / 2) % 2 == 0) ? 2'b01 : 2'b10));
        end
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        cyc();
        cyc();

        // Out-of-range accesses and counter saturation
        do_reset();
        access(1, 0, 64'd4096, 64'h0, 64'h0, 1, "d_oob");
        access(1, 0, 64'h1_0000_0005, 64'h0, 64'h0, 1, "d_hi");
        chk("oob.cnt2", err_count, 8'd2);
        drive(1, 1, 0, 64'h2000_0000, 0);
        n = 0;
        bad = 0;
        for (int i = 0; i < 700 && n < 298; i++) begin
            cyc();
            if (d_gnt) n++;
            if (mem_we || mem_re) bad++;
        end
        cyc();
        drive(1, 0, 0, 0, 0);
        cyc();
        cyc();
        chk("oob.grants", n, 298);
        chk("oob.memact", bad, 0);
        chk("oob.sat", err_count, 8'd255);

        // Debug write followed back-to-back by CPU read of the same word
        do_reset();
        drive(1, 1, 1, 64'd7, 64'h11);
        cyc();
        chk("raw.dgnt", {gnt_w, mem_we}, 3'b101);
        drive(0, 1, 0, 64'd7, 0);
        cyc();
        drive(1, 0, 0, 0, 0);
        chk("raw.ddone", {done_w, busy}, 3'b101);
        cyc();
        chk("raw.cgnt", {gnt_w, mem_re, busy}, 4'b0111);
        cyc();
        drive(0, 0, 0, 0, 0);
        chk("raw.cdone", {done_w, busy}, 3'b011);
        chk("raw.rdata", c_rdata, 64'h11);
        cyc();
        chk("raw.idle", busy, 0);
        ref_mem[7] = 64'h11;

        // Reset during a write access drops it
        do_reset();
        access(0, 1, 64'd9, 64'h22, 64'h0, 0, "c_wr9");
        cyc();
        drive(0, 1, 1, 64'd9, 64'h33);
        cyc();
        chk("rstacc.gnt", {c_gnt, mem_we}, 2'b11);
        rst = 1'b1;
        #1;
        chk("rstacc.outs", {busy, mem_we, mem_re, gnt_w, done_w}, 0);
        cyc();
        drive(0, 0, 0, 0, 0);
        rst = 1'b0;
        cyc();
        access(0, 0, 64'd9, 64'h0, 64'h22, 0, "c_rd9");
        chk("rstacc.cnt", err_count, 0);
        ref_mem[9] = 64'h22;
        cyc();

        // Single-cycle request pulses: exactly one grant and one completion each
        for (int k = 0; k < 4; k++) begin
            dn = 0;
            gn = 0;
            drive(0, 1, 0, 64'(k), 0);
            for (int j = 0; j < 6; j++) begin
                cyc();
                if (j == 1) drive(0, 0, 0, 0, 0);
                if (c_done) dn++;
                if (c_gnt) gn++;
            end
            chk("pulse.gnt", gn, 1);
            chk("pulse.done", dn, 1);
        end

        // Randomised traffic against the scoreboard
        do_reset();
        ref_errs = 0;
        for (int p = 0; p < 2; p++) begin
            a_req[p] = 0; a_pend[p] = 0; a_rel[p] = 0; a_we[p] = 0;
            a_addr[p] = 0; a_wdata[p] = 0; a_wait[p] = 0;
            x_done[p] = 0; x_err[p] = 0; x_rd[p] = 0; hold_rd[p] = 0;
        end
        for (int i = 0; i < 3020; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (a_rel[p]) begin
                    a_rel[p] = 0;
                    a_req[p] = 0;
                end
                if (!a_req[p] && i < 3000 && $urandom_range(0, 2) == 0) begin
                    a_req[p]   = 1;
                    a_pend[p]  = 1;
                    a_wait[p]  = 0;
                    a_we[p]    = 1'($urandom_range(0, 1));
                    a_addr[p]  = rand_addr();
                    a_wdata[p] = {$urandom, $urandom};
                end
                drive(p, a_req[p], a_we[p], a_addr[p], a_wdata[p]);
            end
            cyc();
            chk("rnd.onegnt", gnt_w[0] & gnt_w[1], 0);
            if (gnt_w == 2'b00) chk("rnd.memidle", {mem_we, mem_re}, 0);
            for (int p = 0; p < 2; p++) begin
                chk("rnd.done", done_w[p], x_done[p]);
                if (x_done[p]) begin
                    hold_rd[p] = x_rd[p];
                    chk("rnd.err", err_w[p], x_err[p]);
                    chk("rnd.errcnt", err_count, 64'(ref_errs));
                end else begin
                    chk("rnd.err_idle", err_w[p], 0);
                end
                chk("rnd.rdata", rd_w[p], hold_rd[p]);
                x_done[p] = 0;
                if (gnt_w[p]) begin
                    logic inr;
                    inr = (a_addr[p] < 64'd4096);
                    chk("rnd.spurious", a_pend[p], 1);
                    chk("rnd.wait_ok", a_wait[p] <= 3, 1);
                    chk("rnd.memen", {mem_we, mem_re}, {inr && a_we[p], inr && !a_we[p]});
                    if (inr) chk("rnd.maddr", mem_addr, a_addr[p][11:0]);
                    x_rd[p]  = (inr && !a_we[p]) ? ref_mem[a_addr[p][11:0]] : 64'h0;
                    x_err[p] = !inr;
                    if (inr && a_we[p]) ref_mem[a_addr[p][11:0]] = a_wdata[p];
                    if (!inr && ref_errs < 255) ref_errs++;
                    x_done[p] = 1;
                    a_pend[p] = 0;
                    a_rel[p]  = 1;
                end else if (a_pend[p]) begin
                    a_wait[p]++;
                    if (a_wait[p] > 3) begin
                        chk("rnd.starve", a_wait[p], 3);
                        a_pend[p] = 0;
                        a_rel[p]  = 1;
                    end
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
